keypad_scan: RTL and testbench

Scans a 4x4 matrix keypad and turns debounced key presses into key codes and an 8-bit decimal entry value. It is the input counterpart of the multiplexed seven-segment display path: it drives one column at a time and reads the rows back. The `value_out`/`value_load` pair feeds the 8-bit speed value (`M`) of the LED chaser in place of the slide switches.

---
 rtl/keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, press/release debounce,
// key decode and an 8-bit saturating decimal entry with commit on '#'.
module keypad_scan #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [7:0] entry,
   output logic [7:0] value_out,
   output logic       value_load
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

   state_t          state, state_n;
   logic [DW-1:0]   dwell, dwell_n;
   logic [CW-1:0]   deb_cnt, deb_cnt_n;
   logic [1:0]      col, col_n;
   logic [3:0]      cap_row, cap_row_n;
   logic [3:0]      row_sync_p0, row_s;
   logic [3:0]      key_code_n;
   logic            key_valid_n, key_held_n;

   function automatic logic single_low(input logic [3:0] r);
      case (r)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [3:0] r, input logic [1:0] c);
      logic [1:0] ri;
      case (r)
         4'b1110: ri = 2'd0;
         4'b1101: ri = 2'd1;
         4'b1011: ri = 2'd2;
         default: ri = 2'd3;
      endcase
      case ({ri, c})
         4'd0:    return 4'd1;
         4'd1:    return 4'd2;
         4'd2:    return 4'd3;
         4'd3:    return 4'd10;
         4'd4:    return 4'd4;
         4'd5:    return 4'd5;
         4'd6:    return 4'd6;
         4'd7:    return 4'd11;
         4'd8:    return 4'd7;
         4'd9:    return 4'd8;
         4'd10:   return 4'd9;
         4'd11:   return 4'd12;
         4'd12:   return 4'd14;
         4'd13:   return 4'd0;
         4'd14:   return 4'd15;
         default: return 4'd13;
      endcase
   endfunction

   // Widened to 12 bits so 255*10+9 cannot wrap before the clamp.
   function automatic logic [7:0] sat_entry(input logic [7:0] e, input logic [3:0] d);
      logic [11:0] s;
      s = 12'(e) * 12'd10 + 12'(d);
      return (s > 12'd255) ? 8'd255 : s[7:0];
   endfunction

   always_comb begin
      state_n     = state;
      dwell_n     = dwell;
      deb_cnt_n   = deb_cnt;
      col_n       = col;
      cap_row_n   = cap_row;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
      case (state)
         ST_SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_n = '0;
               if (single_low(row_s)) begin
                  cap_row_n = row_s;
                  deb_cnt_n = '0;
                  state_n   = ST_DEBOUNCE;
               end else begin
                  col_n = col + 2'd1;
               end
            end else begin
               dwell_n = dwell + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (row_s != cap_row) begin
               state_n = ST_SCAN;
               col_n   = col + 2'd1;
            end else if (deb_cnt == DEB_LAST) begin
               state_n     = ST_PRESSED;
               key_code_n  = key_map(cap_row, col);
               key_valid_n = 1'b1;
               key_held_n  = 1'b1;
            end else begin
               deb_cnt_n = deb_cnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (row_s == 4'hF) begin
               state_n   = ST_RELEASE;
               deb_cnt_n = '0;
            end
         end
         ST_RELEASE: begin
            if (row_s != 4'hF) begin
               deb_cnt_n = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n    = ST_SCAN;
               key_held_n = 1'b0;
               col_n      = col + 2'd1;
            end else begin
               deb_cnt_n = deb_cnt + 1'b1;
            end
         end
         default: state_n = ST_SCAN;
      endcase
   end

   // Stage boundary: row synchronizer and FSM/output registers.
   always_ff @(posedge clk) begin
      row_sync_p0 <= row_in;
      row_s       <= row_sync_p0;
      cap_row     <= cap_row_n;
      if (reset) begin
         state     <= ST_SCAN;
         dwell     <= '0;
         deb_cnt   <= '0;
         col       <= 2'd0;
         col_out   <= 4'b1110;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         dwell     <= dwell_n;
         deb_cnt   <= deb_cnt_n;
         col       <= col_n;
         col_out   <= ~(4'b0001 << col_n);
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
      end
   end

   // Stage boundary: accumulator acts on the key_valid cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry      <= 8'd0;
         value_out  <= 8'd0;
         value_load <= 1'b0;
      end else begin
         value_load <= 1'b0;
         if (key_valid) begin
            if (key_code <= 4'd9) begin
               entry <= sat_entry(entry, key_code);
            end else if (key_code == 4'd14) begin
               entry <= 8'd0;
            end else if (key_code == 4'd15) begin
               value_out  <= entry;
               value_load <= 1'b1;
               entry      <= 8'd0;
            end
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix and hand-computed expectations.
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [7:0]  entry;
   logic [7:0]  value_out;
   logic        value_load;
   logic [15:0] pressed;

   int          checks   = 0;
   int          failures = 0;
   int          kv_cnt   = 0;
   int          vl_cnt   = 0;
   logic [3:0]  last_code = 4'd0;
   logic        kv_prev  = 1'b0;
   logic        vl_prev  = 1'b0;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk        (clk),
      .reset      (reset),
      .row_in     (row_in),
      .col_out    (col_out),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_held   (key_held),
      .entry      (entry),
      .value_out  (value_out),
      .value_load (value_load)
   );

   always #5 clk = ~clk;

   // Pressed key at (r,c) pulls row r low while column c is driven.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (key_valid) begin
         kv_cnt++;
         last_code = key_code;
         chk("kv_one_cycle", 32'(kv_prev), 32'd0);
      end
      if (value_load) begin
         vl_cnt++;
         chk("vl_one_cycle", 32'(vl_prev), 32'd0);
      end
      kv_prev = key_valid;
      vl_prev = value_load;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_held(input logic lvl, input string tag);
      int n = 0;
      while (key_held !== lvl && n < 200) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(key_held), 32'(lvl));
   endtask

   task automatic press(input int r, input int c);
      pressed[r*4+c] = 1'b1;
      wait_held(1'b1, "held_rise");
      tick(5);
      pressed[r*4+c] = 1'b0;
      wait_held(1'b0, "held_fall");
      tick(3);
   endtask

   initial begin
      int k0, v0;
      logic [3:0] ecol;
      pressed = '0;
      reset   = 1'b1;
      tick(2);
      chk("rst_col_out",    32'(col_out),    32'hE);
      chk("rst_key_code",   32'(key_code),   32'd0);
      chk("rst_key_valid",  32'(key_valid),  32'd0);
      chk("rst_key_held",   32'(key_held),   32'd0);
      chk("rst_entry",      32'(entry),      32'd0);
      chk("rst_value_out",  32'(value_out),  32'd0);
      chk("rst_value_load", 32'(value_load), 32'd0);

      // Idle scan: four cycles per column, 1110 -> 1101 -> 1011 -> 0111 -> repeat.
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ecol = ~(4'b0001 << ((i / 4) % 4));
         chk("col_scan", 32'(col_out), 32'(ecol));
         tick(1);
      end
      chk("idle_no_kv", kv_cnt, 0);

      // Exact press latency for key 1 held from the first column dwell.
      do_reset();
      k0 = kv_cnt;
      pressed[0] = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         tick(1);
         if (i == 11) chk("lat_kv_before", 32'(key_valid), 32'd0);
         if (i == 12) begin
            chk("lat_kv_edge",  32'(key_valid), 32'd1);
            chk("lat_code",     32'(key_code),  32'd1);
            chk("lat_held",     32'(key_held),  32'd1);
         end
         if (i == 13) begin
            chk("lat_kv_after", 32'(key_valid), 32'd0);
            chk("lat_entry",    32'(entry),     32'd1);
         end
      end
      pressed[0] = 1'b0;
      wait_held(1'b0, "lat_release");
      tick(3);
      chk("lat_kv_count", kv_cnt - k0, 1);

      // Key 5 held steady.
      do_reset();
      k0 = kv_cnt;
      pressed[5] = 1'b1;
      wait_held(1'b1, "k5_held_rise");
      tick(10);
      chk("k5_still_held", 32'(key_held), 32'd1);
      chk("k5_code", 32'(last_code), 32'd5);
      pressed[5] = 1'b0;
      wait_held(1'b0, "k5_held_fall");
      tick(3);
      chk("k5_kv_count", kv_cnt - k0, 1);
      chk("k5_entry", 32'(entry), 32'd5);

      // Key 9 bounces on press and release.
      do_reset();
      k0 = kv_cnt;
      for (int k = 0; k < 20; k++) begin
         if (k % 3 == 0) pressed[10] = ~pressed[10];
         tick(1);
      end
      chk("k9_no_kv_bounce", kv_cnt - k0, 0);
      pressed[10] = 1'b1;
      wait_held(1'b1, "k9_held_rise");
      tick(4);
      for (int k = 0; k < 20; k++) begin
         if (k % 3 == 0) pressed[10] = ~pressed[10];
         tick(1);
      end
      chk("k9_held_in_bounce", 32'(key_held), 32'd1);
      pressed[10] = 1'b0;
      wait_held(1'b0, "k9_held_fall");
      tick(20);
      chk("k9_kv_count", kv_cnt - k0, 1);
      chk("k9_code", 32'(last_code), 32'd9);
      chk("k9_entry", 32'(entry), 32'd9);

      // Sequence 1, 2, 8, # commits 128.
      do_reset();
      v0 = vl_cnt;
      press(0, 0);
      chk("seq_entry_1", 32'(entry), 32'd1);
      press(0, 1);
      chk("seq_entry_12", 32'(entry), 32'd12);
      press(2, 1);
      chk("seq_entry_128", 32'(entry), 32'd128);
      press(3, 2);
      chk("seq_value_out", 32'(value_out), 32'd128);
      chk("seq_vl_count", vl_cnt - v0, 1);
      chk("seq_entry_clr", 32'(entry), 32'd0);

      // Saturation, clear, letter key, and a double press in column 0.
      press(2, 2);
      chk("sat_entry_9", 32'(entry), 32'd9);
      press(2, 2);
      chk("sat_entry_99", 32'(entry), 32'd99);
      press(2, 2);
      chk("sat_entry_255", 32'(entry), 32'd255);
      press(0, 3);
      chk("key_a_code", 32'(last_code), 32'd10);
      chk("key_a_entry", 32'(entry), 32'd255);
      press(3, 0);
      chk("star_clear", 32'(entry), 32'd0);
      k0 = kv_cnt;
      pressed[0] = 1'b1;
      pressed[4] = 1'b1;
      tick(60);
      chk("dual_no_kv", kv_cnt - k0, 0);
      chk("dual_not_held", 32'(key_held), 32'd0);
      pressed = '0;
      tick(5);
      chk("value_kept", 32'(value_out), 32'd128);

      // Reset three cycles into the debounce of '#'.
      do_reset();
      k0 = kv_cnt;
      v0 = vl_cnt;
      pressed[14] = 1'b1;
      tick(14);
      reset = 1'b1;
      tick(1);
      chk("abort_col_out", 32'(col_out), 32'hE);
      chk("abort_kv", 32'(key_valid), 32'd0);
      chk("abort_held", 32'(key_held), 32'd0);
      pressed = '0;
      reset = 1'b0;
      tick(40);
      chk("abort_kv_count", kv_cnt - k0, 0);
      chk("abort_vl_count", vl_cnt - v0, 0);
      chk("abort_value_out", 32'(value_out), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
